dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller in the MEM stage. It serves load/store requests from the pipeline and produces the load word that MEM/WB forwards to the register file write port. On a read miss or any store, it stalls the pipeline and runs a single-word transaction on the backing memory bus. It also keeps hit/miss performance counters.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines, one 32-bit word per line)
TAG_BITS, 32-INDEX_BITS-2, tag width; derived, not overridable

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-low reset
cpu_req  in  1  pipeline access request this cycle
cpu_we  in  1  1=store, 0=load; qualified by cpu_req
cpu_addr  in  32  byte address; bits [1:0] ignored (word access)
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data to MEM/WB
cpu_stall  out  1  freeze pipeline (combinational)
mem_req  out  1  memory transaction request (registered)
mem_we  out  1  memory write (registered)
mem_addr  out  32  word-aligned memory address, [1:0]=0 (registered)
mem_wdata  out  32  memory write data (registered)
mem_rdata  in  32  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse; ignored when mem_req=0
hit_count  out  32  load hits, saturating at 32'hFFFFFFFF
miss_count  out  32  load misses, saturating

Behaviour:
- Address split: index=cpu_addr[INDEX_BITS+1:2], tag=cpu_addr[31:INDEX_BITS+2]. Per line: valid bit, tag, data word.
- hit = cpu_req & valid[index] & (tag_array[index]==tag).
- Reset (rst=0, async): all valid=0, state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counters=0. Tag/data arrays are not reset. Reset mid-transaction aborts it; mem_req drops immediately.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, load hit: cpu_rdata=line data combinationally, cpu_stall=0, hit_count++. Zero added latency.
- IDLE, load miss: cpu_stall=1 the same cycle. At the edge: miss_count++, mem_req<=1, mem_we<=0, mem_addr<={addr[31:2],2'b00}, go to RD_MISS.
- IDLE, store (hit or miss): cpu_stall=1. At the edge: mem_req<=1, mem_we<=1, mem_addr<=word address, mem_wdata<=cpu_wdata, go to WR_THRU. On a hit, update the line data with cpu_wdata at this same edge. A store miss does not allocate.
- IDLE, cpu_req=0: cpu_stall=0, cpu_rdata=0, no state change.
- RD_MISS: cpu_stall=1, cpu_rdata=0. Memory outputs are held stable until mem_ack. On mem_ack: write line (valid=1, tag, mem_rdata), mem_req<=0, go to IDLE. The next cycle the held request re-looks-up and hits (hit_count++). Miss latency is therefore ≥3 cycles.
- WR_THRU: cpu_stall=1. On mem_ack: mem_req<=0, mem_we<=0, go to IDLE. The held store is not reissued because the pipeline advances when cpu_stall=0 in IDLE. To achieve this, IDLE suppresses a store whose address and data match the just-completed write-through for exactly one cycle, via a "wt_done" flag. With wt_done, cpu_stall=0.
- The pipeline holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_stall=1. The controller samples only what it latched into the mem_* registers.
- mem_ack while mem_req=0 is ignored. mem_ack never arrives before the cycle after mem_req rises.
- Counters saturate; they do not wrap.
- Index aliasing: a fill overwrites the line unconditionally (no dirty data exists in a write-through cache).

Test Plan:
- Reset then load 0x0000_0040: cpu_stall=1 and mem_req=1 with mem_addr=0x40 next cycle. Ack with 0xDEADBEEF after 2 cycles → the following cycle cpu_rdata=0xDEADBEEF, stall=0, miss_count=1, hit_count=1.
- Load 0x40 again → same-cycle hit, 0xDEADBEEF, no mem_req, hit_count=2.
- Store 0x12345678 to 0x40 → mem_req=1, mem_we=1, mem_wdata=0x12345678. After ack, stall drops once and no second write is issued. A subsequent load of 0x40 hits with 0x12345678.
- Store to 0x80 (miss), then load 0x80 → memory write occurs, the load still misses (no allocate), miss_count increments.
- Alias: load 0x40 then load 0x440 (same index, different tag) → both miss; the third access to 0x40 misses again.
- Assert rst=0 during RD_MISS before ack → mem_req=0 immediately, state IDLE, counters 0. A later load of 0x40 misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-through, no-write-allocate data cache controller that
// sits in the MEM stage. There is one 32-bit word per line.
// - A load hit returns data in the same cycle.
// - A load miss fills the line from the backing memory. The held request
//   then looks up the cache again and hits.
// - Every store is written through to memory as a single-word write.
//   A store that hits also updates the cached word.
//
// Ports
//   clk          clock, all state changes on posedge
//   rst          asynchronous active-low reset
//   cpu_req      pipeline access request
//   cpu_we       1 = store, 0 = load (qualified by cpu_req)
//   cpu_addr     byte address; bits [1:0] are ignored
//   cpu_wdata    store data
//   cpu_rdata    load data to MEM/WB (0 when not a load hit)
//   cpu_stall    combinational pipeline freeze
//   mem_req      registered memory request
//   mem_we       registered memory write enable
//   mem_addr     registered word-aligned memory address
//   mem_wdata    registered memory write data
//   mem_rdata    memory read data, valid with mem_ack
//   mem_ack      one-cycle completion pulse
//   hit_count    saturating count of load hits
//   miss_count   saturating count of load misses
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR_THRU = 2'd2;

    logic [1:0]            state_reg;
    logic [LINES-1:0]      valid_reg;
    logic [TAG_BITS-1:0]   tag_array  [LINES];
    logic [31:0]           data_array [LINES];

    logic                  mem_req_reg;
    logic                  mem_we_reg;
    logic [29:0]           mem_word_reg;   // word address; the byte offset is always 0
    logic [31:0]           mem_wdata_reg;
    logic [31:0]           hit_count_reg;
    logic [31:0]           miss_count_reg;
    logic                  wt_done_reg;    // a write-through finished on the previous edge

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  wt_match;
    logic                  fill_en;
    logic                  load_hit;
    logic                  load_miss;
    logic                  store_go;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_index  = cpu_addr[INDEX_BITS+1:2];
    assign req_tag    = cpu_addr[31:INDEX_BITS+2];
    // The fill is addressed by the latched request, not by the live pipeline
    // inputs.
    assign fill_index = mem_word_reg[INDEX_BITS-1:0];
    assign fill_tag   = mem_word_reg[29:INDEX_BITS];

    assign hit     = cpu_req & valid_reg[req_index] & (tag_array[req_index] == req_tag);
    assign fill_en = (state_reg == RD_MISS) & mem_req_reg & mem_ack;

    // The store that just completed is still on the pipeline inputs for one
    // cycle after the controller returns to IDLE. Recognise it here so that
    // it is not written a second time.
    assign wt_match = wt_done_reg & cpu_req & cpu_we
                    & (cpu_addr[31:2] == mem_word_reg)
                    & (cpu_wdata == mem_wdata_reg);

    always_comb begin
        cpu_stall = 1'b0;
        cpu_rdata = 32'h0;
        load_hit  = 1'b0;
        load_miss = 1'b0;
        store_go  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_we) begin
                        if (!wt_match) begin
                            cpu_stall = 1'b1;
                            store_go  = 1'b1;
                        end
                    end else if (hit) begin
                        cpu_rdata = data_array[req_index];
                        load_hit  = 1'b1;
                    end else begin
                        cpu_stall = 1'b1;
                        load_miss = 1'b1;
                    end
                end
            end
            RD_MISS: cpu_stall = 1'b1;
            WR_THRU: cpu_stall = 1'b1;
            default: cpu_stall = 1'b0;
        endcase
    end

    // Tag and data storage is not reset. The valid bits alone decide
    // whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_array[fill_index]  <= fill_tag;
            data_array[fill_index] <= mem_rdata;
        end else if (store_go && hit) begin
            data_array[req_index]  <= cpu_wdata;
        end
    end

    // A fill sets the valid bit of its line and never clears it. An alias
    // fill simply overwrites the line, because no dirty data exists.
    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && (fill_index == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_word_reg   <= 30'h0;
            mem_wdata_reg  <= 32'h0;
            hit_count_reg  <= 32'h0;
            miss_count_reg <= 32'h0;
            wt_done_reg    <= 1'b0;
        end else begin
            wt_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                        hit_count_reg <= hit_count_reg + 32'd1;
                    end
                    if (load_miss) begin
                        if (miss_count_reg != 32'hFFFF_FFFF) begin
                            miss_count_reg <= miss_count_reg + 32'd1;
                        end
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_word_reg <= cpu_addr[31:2];
                        state_reg    <= RD_MISS;
                    end
                    if (store_go) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b1;
                        mem_word_reg  <= cpu_addr[31:2];
                        mem_wdata_reg <= cpu_wdata;
                        state_reg     <= WR_THRU;
                    end
                end
                RD_MISS: begin
                    if (mem_req_reg && mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                WR_THRU: begin
                    if (mem_req_reg && mem_ack) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        wt_done_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = {mem_word_reg, 2'b00};
    assign mem_wdata  = mem_wdata_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule
